// File: rtl/dmem_pkg.sv
// dmem_pkg: types and constants shared by the data-memory access controller.
//   dmem_state_t  : controller state (idle / busy on the cache / halted)
//   dmem_op_t     : kind of operation captured from EX/MEM
//   WORD_ADDR_LSB : lowest address bit that selects a word (byte offset below it)
package dmem_pkg;

    localparam int unsigned WORD_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StHalted
    } dmem_state_t;

    typedef enum logic [2:0] {
        OpNone,
        OpLoad,
        OpStore,
        OpLl,
        OpSc
    } dmem_op_t;

endpackage

// File: rtl/dmem_access_link_reg.sv
// link_reg: LL/SC reservation register, built only when DMEM_LLSC_EN is defined.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset (clears the link)
//   set_i          : LL completed; reserve op_word_i
//   clr_i          : store/SC completed to op_word_i; drops a matching reservation
//   op_word_i      : word address of the completing cache access
//   snoop_i        : coherence invalidate for snoop_word_i
//   chk_word_i     : word address of an SC being offered
//   match_o        : reservation is valid and covers chk_word_i
`ifdef DMEM_LLSC_EN
module link_reg
    import dmem_pkg::*;
#(
    parameter int unsigned WordW = 30
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic [WordW-1:0] op_word_i,
    input  logic             snoop_i,
    input  logic [WordW-1:0] snoop_word_i,
    input  logic [WordW-1:0] chk_word_i,
    output logic             match_o
);

    logic             valid_q, valid_d;
    logic [WordW-1:0] addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (set_i) begin
            valid_d = 1'b1;
            addr_d  = op_word_i;
        end else if (clr_i && valid_q && (op_word_i == addr_q)) begin
            valid_d = 1'b0;
        end
        // Compared against the next address so a snoop racing an LL completion
        // to the same word leaves the link invalid.
        if (snoop_i && (snoop_word_i == addr_d)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign match_o = valid_q && (chk_word_i == addr_q);

endmodule
`endif

// File: rtl/dmem_access.sv
// dmem_access: data-memory access controller between the EX/MEM and MEM/WB latches.
// Accepts one op per in_valid/in_ready handshake, runs word reads/writes on the
// data-cache port until dhit, then pulses mem_en with the load result on dload.
// Owns the halt latch and, with DMEM_LLSC_EN defined, the LL/SC link register.
// Ports:
//   CLK, nRST                  : clock, asynchronous active-low reset
//   in_valid / in_ready        : operation handshake from EX/MEM
//   in_ren, in_wen, in_ll,
//   in_sc, in_halt, in_addr,
//   in_wdata                   : operation fields, sampled on handshake
//   flush                      : squash current and pending result
//   dmemREN, dmemWEN, dmemaddr,
//   dmemstore, dhit, dmemload  : data-cache port
//   snoop_inv, snoop_addr      : coherence invalidate (LL/SC builds only)
//   mem_en, dload, halt_o      : MEM/WB outputs
// Build option: DMEM_LLSC_EN enables LL/SC; otherwise LL is a load, SC a store.
module dmem_access #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_ren,
    input  logic              in_wen,
    input  logic              in_ll,
    input  logic              in_sc,
    input  logic              in_halt,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              flush,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [ADDR_W-1:0] dmemaddr,
    output logic [DATA_W-1:0] dmemstore,
    input  logic              dhit,
    input  logic [DATA_W-1:0] dmemload,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              mem_en,
    output logic [DATA_W-1:0] dload,
    output logic              halt_o
);
    import dmem_pkg::*;

    localparam int unsigned WordW = ADDR_W - WORD_ADDR_LSB;

    dmem_state_t       state_q, state_d;
    dmem_op_t          op_q, op_d;
    logic [WordW-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              squash_q, squash_d;
    logic              mem_en_q, mem_en_d;
    logic [DATA_W-1:0] dload_q, dload_d;
    logic              halt_q, halt_d;

    dmem_op_t          in_op;
    logic              sc_fail;
    logic              squash_now;
    logic              busy_done;

    assign squash_now = squash_q || flush;
    assign busy_done  = (state_q == StBusy) && dhit;

    // Decode the offered op; LL/SC qualifiers only matter in LL/SC builds.
    always_comb begin
        in_op = OpNone;
        if (in_ren) begin
            in_op = OpLoad;
`ifdef DMEM_LLSC_EN
            if (in_ll) in_op = OpLl;
`endif
        end else if (in_wen) begin
            in_op = OpStore;
`ifdef DMEM_LLSC_EN
            if (in_sc) in_op = OpSc;
`endif
        end
    end

`ifdef DMEM_LLSC_EN
    logic link_set, link_clr, link_match;

    // A squashed LL does not reserve; a squashed store/SC still wrote memory.
    assign link_set = busy_done && (op_q == OpLl) && !squash_now;
    assign link_clr = busy_done && ((op_q == OpStore) || (op_q == OpSc));
    assign sc_fail  = (in_op == OpSc) && !link_match;

    link_reg #(
        .WordW (WordW)
    ) u_link_reg (
        .clk_i        (CLK),
        .rst_ni       (nRST),
        .set_i        (link_set),
        .clr_i        (link_clr),
        .op_word_i    (waddr_q),
        .snoop_i      (snoop_inv),
        .snoop_word_i (snoop_addr[ADDR_W-1:WORD_ADDR_LSB]),
        .chk_word_i   (in_addr[ADDR_W-1:WORD_ADDR_LSB]),
        .match_o      (link_match)
    );

    logic unused_bits;
    assign unused_bits = ^{in_addr[WORD_ADDR_LSB-1:0], snoop_addr[WORD_ADDR_LSB-1:0]};
`else
    assign sc_fail = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{in_ll, in_sc, snoop_inv, snoop_addr, in_addr[WORD_ADDR_LSB-1:0]};
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        waddr_d  = waddr_q;
        store_d  = store_q;
        ren_d    = ren_q;
        wen_d    = wen_q;
        squash_d = squash_q;
        mem_en_d = 1'b0;
        dload_d  = dload_q;
        halt_d   = halt_q;

        case (state_q)
            StIdle: begin
                // A flushed offer is dropped outright, including a halt.
                if (in_valid && !flush) begin
                    if (in_halt) begin
                        mem_en_d = 1'b1;
                        halt_d   = 1'b1;
                        state_d  = StHalted;
                    end else if ((in_op == OpNone) || sc_fail) begin
                        dload_d  = '0;
                        mem_en_d = 1'b1;
                    end else begin
                        op_d     = in_op;
                        waddr_d  = in_addr[ADDR_W-1:WORD_ADDR_LSB];
                        store_d  = in_wdata;
                        ren_d    = (in_op == OpLoad) || (in_op == OpLl);
                        wen_d    = (in_op == OpStore) || (in_op == OpSc);
                        squash_d = 1'b0;
                        state_d  = StBusy;
                    end
                end
            end
            StBusy: begin
                // The cache access cannot be abandoned; flush only hides the result.
                if (flush) squash_d = 1'b1;
                if (dhit) begin
                    state_d  = StIdle;
                    ren_d    = 1'b0;
                    wen_d    = 1'b0;
                    squash_d = 1'b0;
                    if (!squash_now) begin
                        mem_en_d = 1'b1;
                        case (op_q)
                            OpLoad, OpLl: dload_d = dmemload;
                            OpSc:         dload_d = {{(DATA_W-1){1'b0}}, 1'b1};
                            default:      ;
                        endcase
                    end
                end
            end
            StHalted: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= StIdle;
            op_q     <= OpNone;
            waddr_q  <= '0;
            store_q  <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            squash_q <= 1'b0;
            mem_en_q <= 1'b0;
            dload_q  <= '0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            waddr_q  <= waddr_d;
            store_q  <= store_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            squash_q <= squash_d;
            mem_en_q <= mem_en_d;
            dload_q  <= dload_d;
            halt_q   <= halt_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign dmemREN   = ren_q;
    assign dmemWEN   = wen_q;
    assign dmemaddr  = {waddr_q, {WORD_ADDR_LSB{1'b0}}};
    assign dmemstore = store_q;
    assign mem_en    = mem_en_q;
    assign dload     = dload_q;
    assign halt_o    = halt_q;

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed scenarios followed by random
// operations, compared against a transaction-level model of the controller.
module tb_dmem_access;

`ifdef DMEM_LLSC_EN
    localparam bit LlscEn = 1'b1;
`else
    localparam bit LlscEn = 1'b0;
`endif

    logic        CLK, nRST;
    logic        in_valid, in_ready, in_ren, in_wen, in_ll, in_sc, in_halt;
    logic [31:0] in_addr, in_wdata;
    logic        flush, dmemREN, dmemWEN, dhit, snoop_inv, mem_en, halt_o;
    logic [31:0] dmemaddr, dmemstore, dmemload, snoop_addr, dload;

    dmem_access #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ren     (in_ren),
        .in_wen     (in_wen),
        .in_ll      (in_ll),
        .in_sc      (in_sc),
        .in_halt    (in_halt),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .flush      (flush),
        .dmemREN    (dmemREN),
        .dmemWEN    (dmemWEN),
        .dmemaddr   (dmemaddr),
        .dmemstore  (dmemstore),
        .dhit       (dhit),
        .dmemload   (dmemload),
        .snoop_inv  (snoop_inv),
        .snoop_addr (snoop_addr),
        .mem_en     (mem_en),
        .dload      (dload),
        .halt_o     (halt_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state: reservation, last result, halt.
    bit          m_link_v;
    logic [29:0] m_link_w;
    logic [31:0] m_dload;
    bit          m_halted;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic snoop_model(input logic [31:0] saddr);
        if (m_link_v && (m_link_w == saddr[31:2])) m_link_v = 1'b0;
    endtask

    // One op offered in IDLE. lat = BUSY cycle carrying dhit (>=1);
    // flush_at: 0 = with the offer, k = BUSY cycle k, -1 = none;
    // snoop_at: BUSY cycle carrying snoop_inv, -1 = none.
    task automatic run_op(input bit ren, input bit wen, input bit ll, input bit sc,
                          input bit hlt, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [31:0] rdata, input int flush_at,
                          input int snoop_at, input logic [31:0] saddr);
        int kind;  // 0 none, 1 load, 2 store, 3 LL, 4 SC
        bit squash;
        bit sc_ok;
        squash = 1'b0;
        kind = ren ? ((LlscEn && ll) ? 3 : 1) : (wen ? ((LlscEn && sc) ? 4 : 2) : 0);
        sc_ok = m_link_v && (m_link_w == addr[31:2]);
        check_b("ready_idle", in_ready, 1'b1);
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_ll = ll; in_sc = sc;
        in_halt = hlt; in_addr = addr; in_wdata = wdata; flush = (flush_at == 0);
        step();
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_ll = 1'b0; in_sc = 1'b0;
        in_halt = 1'b0; flush = 1'b0;
        if (flush_at == 0) begin
            check_b("drop_mem_en", mem_en, 1'b0);
            check_b("drop_req", dmemREN | dmemWEN, 1'b0);
            check_b("drop_halt", halt_o, m_halted);
            check_b("drop_ready", in_ready, 1'b1);
            return;
        end
        if (hlt) begin
            m_halted = 1'b1;
            check_b("halt_mem_en", mem_en, 1'b1);
            check_b("halt_o", halt_o, 1'b1);
            check_b("halt_ready", in_ready, 1'b0);
            return;
        end
        if (kind == 0 || (kind == 4 && !sc_ok)) begin
            m_dload = 32'h0;
            check_b("fast_mem_en", mem_en, 1'b1);
            check_w("fast_dload", dload, m_dload);
            check_b("fast_noreq", dmemREN | dmemWEN, 1'b0);
            return;
        end
        for (int k = 1; k <= lat; k++) begin
            check_b("busy_ready", in_ready, 1'b0);
            check_b("busy_ren", dmemREN, (kind == 1 || kind == 3));
            check_b("busy_wen", dmemWEN, (kind == 2 || kind == 4));
            check_w("busy_addr", dmemaddr, {addr[31:2], 2'b00});
            if (wen) check_w("busy_store", dmemstore, wdata);
            check_b("busy_mem_en", mem_en, 1'b0);
            flush = (k == flush_at);
            snoop_inv = (k == snoop_at);
            snoop_addr = saddr;
            dhit = (k == lat);
            dmemload = (k == lat) ? rdata : $urandom;
            step();
            flush = 1'b0; snoop_inv = 1'b0; dhit = 1'b0;
            if (k == flush_at) squash = 1'b1;
            if (k < lat && k == snoop_at) snoop_model(saddr);
        end
        if ((kind == 2 || kind == 4) && m_link_v && (m_link_w == addr[31:2])) m_link_v = 1'b0;
        if (kind == 3 && !squash) begin
            m_link_v = 1'b1;
            m_link_w = addr[31:2];
        end
        if (snoop_at == lat) snoop_model(saddr);
        if (!squash) begin
            if (kind == 1 || kind == 3) m_dload = rdata;
            else if (kind == 4) m_dload = 32'h1;
        end
        check_b("done_mem_en", mem_en, !squash);
        check_w("done_dload", dload, m_dload);
        check_b("done_noreq", dmemREN | dmemWEN, 1'b0);
        check_b("done_ready", in_ready, 1'b1);
    endtask

    // Cycle with nothing offered; optional snoop and a stray dhit.
    task automatic idle_cycle(input bit snp, input logic [31:0] saddr, input bit hit);
        snoop_inv = snp; snoop_addr = saddr; dhit = hit; dmemload = $urandom;
        step();
        snoop_inv = 1'b0; dhit = 1'b0;
        if (snp) snoop_model(saddr);
        check_b("idle_mem_en", mem_en, 1'b0);
        check_w("idle_dload", dload, m_dload);
        check_b("idle_noreq", dmemREN | dmemWEN, 1'b0);
    endtask

    logic [31:0] pool [4];
    int          sel, lat, fl, sn;
    bit          r, w;

    initial begin
        pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h200; pool[3] = 32'h300;
        m_link_v = 1'b0; m_link_w = '0; m_dload = '0; m_halted = 1'b0;
        nRST = 1'b0; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_ll = 1'b0;
        in_sc = 1'b0; in_halt = 1'b0; in_addr = '0; in_wdata = '0; flush = 1'b0;
        dhit = 1'b0; dmemload = '0; snoop_inv = 1'b0; snoop_addr = '0;
        repeat (2) step();
        check_b("rst_mem_en", mem_en, 1'b0);
        check_w("rst_dload", dload, 32'h0);
        check_b("rst_halt", halt_o, 1'b0);
        check_b("rst_req", dmemREN | dmemWEN, 1'b0);
        check_w("rst_addr", dmemaddr, 32'h0);
        check_b("rst_ready", in_ready, 1'b1);
        nRST = 1'b1;
        step();

        // Load with dhit in the third BUSY cycle.
        run_op(1, 0, 0, 0, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF, -1, -1, 32'h0);
        idle_cycle(0, 32'h0, 0);
        // LL then SC to the same word, then a second SC.
        run_op(1, 0, 1, 0, 0, 32'h200, 32'h0, 1, 32'h11112222, -1, -1, 32'h0);
        run_op(0, 1, 0, 1, 0, 32'h200, 32'h5, 2, 32'h0, -1, -1, 32'h0);
        run_op(0, 1, 0, 1, 0, 32'h200, 32'h6, 1, 32'h0, -1, -1, 32'h0);
        // Snoop between LL and SC, then snoop racing the LL completion.
        run_op(1, 0, 1, 0, 0, 32'h300, 32'h0, 2, 32'h33334444, -1, -1, 32'h0);
        idle_cycle(1, 32'h302, 0);
        run_op(0, 1, 0, 1, 0, 32'h300, 32'h7, 1, 32'h0, -1, -1, 32'h0);
        run_op(1, 0, 1, 0, 0, 32'h300, 32'h0, 2, 32'h55556666, -1, 2, 32'h300);
        run_op(0, 1, 0, 1, 0, 32'h300, 32'h8, 1, 32'h0, -1, -1, 32'h0);
        // Flushed store, stray dhit, non-memory op, flushed halt.
        run_op(0, 1, 0, 0, 0, 32'h404, 32'hCAFE, 3, 32'h0, 1, -1, 32'h0);
        idle_cycle(0, 32'h0, 1);
        run_op(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, -1, -1, 32'h0);
        run_op(0, 0, 0, 0, 1, 32'h0, 32'h0, 1, 32'h0, 0, -1, 32'h0);

        // Reset while a load is outstanding; an earlier LL reservation must die.
        run_op(1, 0, 1, 0, 0, 32'h40, 32'h0, 1, 32'h12345678, -1, -1, 32'h0);
        in_valid = 1'b1; in_ren = 1'b1; in_addr = 32'h40;
        step();
        in_valid = 1'b0; in_ren = 1'b0;
        check_b("pre_rst_ren", dmemREN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        m_link_v = 1'b0; m_dload = '0;
        check_b("midrst_ren", dmemREN, 1'b0);
        check_b("midrst_ready", in_ready, 1'b1);
        check_b("midrst_mem_en", mem_en, 1'b0);
        check_w("midrst_dload", dload, 32'h0);
        step();
        nRST = 1'b1;
        run_op(0, 1, 0, 1, 0, 32'h40, 32'h9, 1, 32'h0, -1, -1, 32'h0);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            r = (sel < 4);
            w = (sel >= 4 && sel < 8);
            lat = $urandom_range(1, 4);
            fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, lat)) : -1;
            sn = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : -1;
            run_op(r, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                   pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)), $urandom,
                   lat, $urandom, fl, sn, pool[$urandom_range(0, 3)]);
            if ($urandom_range(0, 3) == 0)
                idle_cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
                           1'($urandom_range(0, 1)));
        end

        // Halt, then keep offering a load: nothing more may happen.
        run_op(0, 0, 0, 0, 1, 32'h0, 32'h0, 1, 32'h0, -1, -1, 32'h0);
        in_valid = 1'b1; in_ren = 1'b1; in_addr = 32'h100;
        for (int n = 0; n < 4; n++) begin
            step();
            check_b("halted_ready", in_ready, 1'b0);
            check_b("halted_ren", dmemREN, 1'b0);
            check_b("halted_mem_en", mem_en, 1'b0);
            check_b("halted_halt", halt_o, m_halted);
        end
        in_valid = 1'b0; in_ren = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
